// File: rtl/shadow_snap_fifo.sv
// shadow_snap_fifo: multi-entry shadow capture buffer.
// Snapshots din into a DEPTH-deep FIFO; dumps oldest as CHUNK-bit beats.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   c_en, din  capture enable and WIDTH-bit host data
//   dump_req   start dumping the oldest snapshot
//   dout, dout_valid, dout_last, dout_ready  beat stream (valid/ready)
//   q_ready    count != 0
//   full       count == DEPTH
//   count      held snapshots
//   ovf        sticky overflow, cleared by clr_ovf
//
// Optional: define SHADOW_TAG_EN to store a CHUNK-bit cycle tag per
// snapshot, emitted as beat 0 ahead of the data beats.
module shadow_snap_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CHUNK = 8,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_en,
  input  logic [WIDTH-1:0] din,
  input  logic             dump_req,
  output logic [CHUNK-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             q_ready,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int BEATS = WIDTH / CHUNK;
`ifdef SHADOW_TAG_EN
  localparam int BEATS_EFF = BEATS + 1;
`else
  localparam int BEATS_EFF = BEATS;
`endif
  localparam int PW = $clog2(DEPTH);
  localparam int BW = (BEATS_EFF > 1) ? $clog2(BEATS_EFF) : 1;
  localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, DUMP} state_t;

  state_t state_q, state_d;

  logic [BEATS-1:0][CHUNK-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] beat;
  logic [IW-1:0] di;

  logic dumping, accept, last, retire;
  logic cap, ovf_set;

  assign q_ready = (count != '0);
  assign full    = (count == CW'(DEPTH));

  assign dumping = (state_q == DUMP);
  assign accept  = dumping & dout_ready;
  assign last    = dumping && (beat == BW'(BEATS_EFF-1));
  assign retire  = accept & last;

  // full is judged before any same-cycle retire: that slot is not free yet
  assign cap     = c_en & ~full;
  assign ovf_set = c_en & full;

  assign dout_valid = dumping;
  assign dout_last  = last;

`ifdef SHADOW_TAG_EN
  logic [CHUNK-1:0] cyc;
  logic [CHUNK-1:0] tag_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + CHUNK'(1);
  end

  always_ff @(posedge clk) begin
    if (cap) tag_mem[wr_ptr] <= cyc;
  end

  assign di = IW'(beat - BW'(1));

  always_comb begin
    dout = '0;
    if (dumping) begin
      if (beat == '0) dout = tag_mem[rd_ptr];
      else            dout = mem[rd_ptr][di];
    end
  end
`else
  assign di = IW'(beat);

  always_comb begin
    dout = '0;
    if (dumping) dout = mem[rd_ptr][di];
  end
`endif

  always_ff @(posedge clk) begin
    if (cap) mem[wr_ptr] <= din;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (dump_req && q_ready) state_d = DUMP;
      DUMP: if (retire) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (accept) begin
      if (last) beat <= '0;
      else      beat <= beat + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (cap) begin
        if (wr_ptr == PW'(DEPTH-1)) wr_ptr <= '0;
        else                        wr_ptr <= wr_ptr + PW'(1);
      end
      if (retire) begin
        if (rd_ptr == PW'(DEPTH-1)) rd_ptr <= '0;
        else                        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        cap & ~retire: count <= count + CW'(1);
        ~cap & retire: count <= count - CW'(1);
        default:       count <= count;
      endcase
    end
  end

  // a simultaneous overflow beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_shadow_snap_fifo.sv
// tb_shadow_snap_fifo: directed self-checking bench for shadow_snap_fifo.
// Default build: WIDTH=32, DEPTH=4, CHUNK=8, four beats per snapshot.
module tb_shadow_snap_fifo;

  logic        clk;
  logic        rst;
  logic        c_en;
  logic [31:0] din;
  logic        dump_req;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        q_ready;
  logic        full;
  logic [2:0]  count;
  logic        ovf;
  logic        clr_ovf;

  int checks = 0;
  int errors = 0;

  shadow_snap_fifo #(.WIDTH(32), .DEPTH(4), .CHUNK(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .c_en       (c_en),
    .din        (din),
    .dump_req   (dump_req),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .q_ready    (q_ready),
    .full       (full),
    .count      (count),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [31:0] v);
    c_en = 1'b1;
    din  = v;
    tick();
    c_en = 1'b0;
  endtask

  // dump one snapshot with ready held high; optionally capture on last beat
  task automatic dump_expect(input string tag, input logic [31:0] v,
                             input logic cap_last, input logic [31:0] cv);
    logic [31:0] w;
    w = v;
    dout_ready = 1'b1;
    dump_req   = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
      chk({tag, "_dout"},  32'(dout), 32'(w[b*8 +: 8]));
      chk({tag, "_last"},  32'(dout_last), 32'(b == 3));
      if (b == 3 && cap_last) begin
        c_en = 1'b1;
        din  = cv;
      end
      tick();
      c_en = 1'b0;
    end
    chk({tag, "_vdrop"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    c_en       = 1'b0;
    din        = '0;
    dump_req   = 1'b0;
    dout_ready = 1'b0;
    clr_ovf    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_qrdy",  32'(q_ready), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_last",  32'(dout_last), 32'd0);
    chk("rst_dout",  32'(dout), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    chk("rst_full",  32'(full), 32'd0);

    // empty dump request is ignored
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("empty_dump", 32'(dout_valid), 32'd0);

    // basic capture and dump
    capture(32'hA1B2C3D4);
    chk("cap_count", 32'(count), 32'd1);
    chk("cap_qrdy",  32'(q_ready), 32'd1);
    dump_expect("d1", 32'hA1B2C3D4, 1'b0, 32'h0);
    chk("d1_count", 32'(count), 32'd0);
    chk("d1_qrdy",  32'(q_ready), 32'd0);

    // overflow
    for (int i = 1; i <= 5; i++) capture(32'(i));
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_full",  32'(full), 32'd1);
    chk("ovf_flag",  32'(ovf), 32'd1);
    dump_expect("o1", 32'd1, 1'b0, 32'h0);
    dump_expect("o2", 32'd2, 1'b0, 32'h0);
    dump_expect("o3", 32'd3, 1'b0, 32'h0);
    dump_expect("o4", 32'd4, 1'b0, 32'h0);
    chk("ovf_drain", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // backpressure mid-dump
    capture(32'h11223344);
    dout_ready = 1'b1;
    dump_req   = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("bp_b0", 32'(dout), 32'h44);
    tick();
    dout_ready = 1'b0;
    chk("bp_b1", 32'(dout), 32'h33);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_dout",  32'(dout), 32'h33);
      chk("bp_hold_valid", 32'(dout_valid), 32'd1);
      chk("bp_hold_last",  32'(dout_last), 32'd0);
    end
    dout_ready = 1'b1;
    tick();
    chk("bp_b2", 32'(dout), 32'h22);
    tick();
    chk("bp_b3", 32'(dout), 32'h11);
    chk("bp_last", 32'(dout_last), 32'd1);
    tick();
    chk("bp_end", 32'(dout_valid), 32'd0);
    chk("bp_count", 32'(count), 32'd0);

    // full FIFO, capture on final accepted beat is dropped
    for (int i = 0; i < 4; i++) capture(32'hF0000000 | 32'(i));
    dump_expect("fr0", 32'hF0000000, 1'b1, 32'hDEADBEEF);
    chk("fr_ovf",   32'(ovf), 32'd1);
    chk("fr_count", 32'(count), 32'd3);
    dump_expect("fr1", 32'hF0000001, 1'b0, 32'h0);
    dump_expect("fr2", 32'hF0000002, 1'b0, 32'h0);
    dump_expect("fr3", 32'hF0000003, 1'b0, 32'h0);
    chk("fr_empty", 32'(q_ready), 32'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    // non-full FIFO, capture on final beat is kept, count unchanged
    capture(32'hC0C0C001);
    capture(32'hC0C0C002);
    dump_expect("nr0", 32'hC0C0C001, 1'b1, 32'hC0C0C003);
    chk("nr_count", 32'(count), 32'd2);
    chk("nr_ovf",   32'(ovf), 32'd0);
    dump_expect("nr1", 32'hC0C0C002, 1'b0, 32'h0);
    dump_expect("nr2", 32'hC0C0C003, 1'b0, 32'h0);
    chk("nr_empty", 32'(count), 32'd0);

    // asynchronous reset mid-dump
    capture(32'h55667788);
    dout_ready = 1'b1;
    dump_req   = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    chk("ar_b1", 32'(dout), 32'h77);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(dout_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_qrdy",  32'(q_ready), 32'd0);
    chk("ar_dout",  32'(dout), 32'd0);
    #1 rst = 1'b0;
    tick();
    capture(32'h0BADF00D);
    dump_expect("ar_new", 32'h0BADF00D, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
